// File: rtl/add_seq8_ctrl_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer.
package add_seq8_ctrl_pkg;

  localparam int NBYTES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_seq8_ctrl_ra8.sv
// RA8: 8-bit ripple-carry adder, the single shared byte datapath.
module add_seq8_ctrl_ra8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  logic c;

  always_comb begin
    s = '0;
    c = ci;
    for (int i = 0; i < 8; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/add_seq8_ctrl.sv
// Wide add/subtract sequencer: one byte per clock through a shared RA8,
// LSB first, with a start/busy/done handshake.
module add_seq8_ctrl
  import add_seq8_ctrl_pkg::*;
#(
  parameter  int NBYTES = NBYTES_DEF,
  localparam int W      = 8 * NBYTES,
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         overflow,
  output logic         busy,
  output logic         done
);

  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  state_t                 state, state_nx;
  logic [CW-1:0]          idx;
  logic [W-1:0]           a_r, b_r, a_sh, b_sh;
  logic [NBYTES-1:0][7:0] sum_r;
  logic                   cy, c_out_r, ovf_r;
  logic [7:0]             ra_sum;
  logic                   ra_co;
  logic                   accept, last;

  // Shifting rather than part-selecting keeps the NBYTES=1 build free of
  // zero-width index arithmetic.
  assign a_sh = a_r >> {idx, 3'b000};
  assign b_sh = b_r >> {idx, 3'b000};
  assign last = (idx == LAST);

  add_seq8_ctrl_ra8 u_ra8 (
    .a  (a_sh[7:0]),
    .b  (b_sh[7:0]),
    .ci (cy),
    .s  (ra_sum),
    .co (ra_co)
  );

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        accept   = 1'b1;
        state_nx = ST_RUN;
      end
      ST_RUN:  if (last) state_nx = ST_DONE;
      ST_DONE: begin
        accept   = start;
        state_nx = start ? ST_RUN : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      cy      <= 1'b0;
      sum_r   <= '0;
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept) begin
      // Subtract is a + ~b + 1; b is stored pre-inverted so RUN is add-only.
      a_r   <= a;
      b_r   <= sub ? ~b : b;
      cy    <= sub | c_in;
      idx   <= '0;
      sum_r <= '0;
    end else if (state == ST_RUN) begin
      for (int i = 0; i < NBYTES; i++)
        if (idx == CW'(i)) sum_r[i] <= ra_sum;
      cy  <= ra_co;
      idx <= last ? '0 : idx + 1'b1;
      if (last) begin
        c_out_r <= ra_co;
        ovf_r   <= (a_r[W-1] == b_r[W-1]) && (ra_sum[7] != a_r[W-1]);
      end
    end
  end

  assign sum      = sum_r;
  assign c_out    = c_out_r;
  assign overflow = ovf_r;
  assign busy     = (state == ST_RUN);
  assign done     = (state == ST_DONE);

endmodule
